// File: rtl/snes_poll_controller.sv
// Polls an SNES pad: latch pulse plus NUM_BITS shift clocks. Returns an active-high word with a one-cycle valid
// LATCH_CYCLES+2*HALF_CYCLES*NUM_BITS+1 cycles after the trigger; start is ignored while busy, auto expiry is held pending.
module snes_poll_controller #(
    parameter int HALF_CYCLES  = 300,
    parameter int LATCH_CYCLES = 600,
    parameter int NUM_BITS     = 16,
    parameter int POLL_CYCLES  = 833333
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_en,
    input  logic        snes_data,
    output logic        snes_latch,
    output logic        snes_clk,
    output logic [15:0] buttons,
    output logic        valid,
    output logic        busy
);

    localparam int MAX_A   = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int MAX_CYC = (POLL_CYCLES > MAX_A) ? POLL_CYCLES : MAX_A;
    localparam int CW      = $clog2(MAX_CYC + 1);

    localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
    localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_CYCLES - 1);
    localparam logic [4:0]    BIT_LAST   = 5'(NUM_BITS - 1);

    typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] phase_cnt_q, phase_cnt_d;
    logic [CW-1:0] poll_cnt_q, poll_cnt_d;
    logic [4:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   shift_q, shift_d;
    logic [15:0]   buttons_q, buttons_d;
    logic          sync1_q, sync1_d, sync2_q, sync2_d;
    logic          auto_en_q, auto_en_d;
    logic          pending_q, pending_d;
    logic          snes_latch_q, snes_latch_d;
    logic          snes_clk_q, snes_clk_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          auto_req;
    logic          enter_latch;

    always_comb begin
        state_d     = state_q;
        phase_cnt_d = phase_cnt_q + 1'b1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        buttons_d   = buttons_q;
        sync1_d     = snes_data;
        sync2_d     = sync1_q;
        auto_en_d   = auto_en;

        // A rising auto_en counts as an already-expired interval.
        auto_req = auto_en && (!auto_en_q || pending_q || (poll_cnt_q == POLL_LAST));

        case (state_q)
            IDLE: begin
                phase_cnt_d = '0;
                if (start || auto_req) begin
                    state_d   = LATCH;
                    bit_idx_d = '0;
                    shift_d   = '0;
                end
            end
            LATCH: begin
                if (phase_cnt_q == LATCH_LAST) begin
                    state_d     = LOW;
                    phase_cnt_d = '0;
                    bit_idx_d   = '0;
                end
            end
            LOW: begin
                if (phase_cnt_q == HALF_LAST) begin
                    shift_d[bit_idx_q[3:0]] = ~sync2_q;
                    state_d     = HIGH;
                    phase_cnt_d = '0;
                end
            end
            HIGH: begin
                if (phase_cnt_q == HALF_LAST) begin
                    phase_cnt_d = '0;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d   = DONE;
                        buttons_d = shift_q;
                    end else begin
                        state_d   = LOW;
                        bit_idx_d = bit_idx_q + 5'd1;
                    end
                end
            end
            DONE: begin
                state_d     = IDLE;
                phase_cnt_d = '0;
            end
            default: begin
                state_d     = IDLE;
                phase_cnt_d = '0;
            end
        endcase

        enter_latch = (state_q == IDLE) && (state_d == LATCH);

        // Interval runs from each LATCH entry and parks at its last count until served.
        if (!auto_en || enter_latch) begin
            poll_cnt_d = '0;
        end else if (poll_cnt_q != POLL_LAST) begin
            poll_cnt_d = poll_cnt_q + 1'b1;
        end else begin
            poll_cnt_d = poll_cnt_q;
        end
        pending_d = auto_req && !enter_latch;

        snes_latch_d = (state_d == LATCH);
        snes_clk_d   = (state_d != LOW);
        busy_d       = (state_d != IDLE);
        valid_d      = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            phase_cnt_q  <= '0;
            poll_cnt_q   <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            buttons_q    <= '0;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            auto_en_q    <= 1'b0;
            pending_q    <= 1'b0;
            snes_latch_q <= 1'b0;
            snes_clk_q   <= 1'b1;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_cnt_q  <= phase_cnt_d;
            poll_cnt_q   <= poll_cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            buttons_q    <= buttons_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            auto_en_q    <= auto_en_d;
            pending_q    <= pending_d;
            snes_latch_q <= snes_latch_d;
            snes_clk_q   <= snes_clk_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    assign snes_latch = snes_latch_q;
    assign snes_clk   = snes_clk_q;
    assign buttons    = buttons_q;
    assign valid      = valid_q;
    assign busy       = busy_q;

endmodule

// File: doc/snes_poll_controller.md
Name: snes_poll_controller

Overview:
- Host-side sequencer for an SNES-style serial pad (latch/clock/data).
- Generates the latch pulse and 16 clock pulses, samples the serial data line and assembles an active-high button word.
- Issues one-cycle valid strobes to downstream game/test logic.
- Polls on request, or periodically when auto mode is enabled.

Parameters:
- HALF_CYCLES, 300: clk cycles per snes_clk half-period (6 us at 50 MHz); must be >= 4.
- LATCH_CYCLES, 600: clk cycles snes_latch is held high (12 us at 50 MHz); must be >= 1.
- NUM_BITS, 16: serial bits read per poll (12 buttons + 4 ID bits); range 1..16.
- POLL_CYCLES, 833333: auto-poll interval in clk cycles, start-to-start (60 Hz at 50 MHz); must exceed one poll length.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: single poll request; sampled only in IDLE.
- auto_en, in, 1: enables periodic polling every POLL_CYCLES.
- snes_data, in, 1: serial data from pad, active-low (0 = pressed); asynchronous to clk.
- snes_latch, out, 1: latch to pad, active-high.
- snes_clk, out, 1: shift clock to pad; idles high.
- buttons, out, 16: last completed word, active-high. Bit i = ~serial bit i; bits >= NUM_BITS read 0.
  - Order: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R, 12-15 ID.
- valid, out, 1: one-cycle pulse when buttons is updated.
- busy, out, 1: high from LATCH entry through the DONE cycle.

Behaviour:
- Reset values (asynchronous): snes_latch=0, snes_clk=1, buttons=0, valid=0, busy=0, FSM=IDLE, all counters=0, synchronizer=1.
- Reset mid-poll aborts immediately; no valid is issued; buttons is cleared.
- Input path: snes_data passes through a 2-FF synchronizer; all sampling uses the synchronized value.
- FSM states: IDLE, LATCH, LOW, HIGH, DONE. All outputs are registered.
  - IDLE: snes_latch=0, snes_clk=1, busy=0.
    - Go to LATCH on the cycle after (start=1) or (auto_en=1 and interval counter expired).
  - LATCH: snes_latch=1, busy=1, for exactly LATCH_CYCLES cycles, then go to LOW with bit index=0.
  - LOW: snes_latch=0, snes_clk=0, for HALF_CYCLES cycles.
    - On the last LOW cycle, shift ~sync_data into shift register position [bit index].
  - HIGH: snes_clk=1, for HALF_CYCLES cycles. The pad shifts on this rising edge.
    - On the last HIGH cycle: if bit index = NUM_BITS-1, go to DONE; else increment the index and go to LOW.
  - DONE: one cycle. buttons <= shift register; valid=1, busy=1; then go to IDLE.
- Poll length: LATCH_CYCLES + 2*HALF_CYCLES*NUM_BITS cycles from the first snes_latch=1 cycle to the DONE cycle exclusive.
  - NUM_BITS=16 gives exactly 16 falling and 16 rising snes_clk edges per poll, with no glitches.
- Auto mode:
  - Interval counter counts clk cycles from each LATCH entry.
  - Expiry at POLL_CYCLES triggers a poll if the FSM is in IDLE; otherwise the request is held pending until IDLE.
  - auto_en=0 clears the counter and any pending request.
  - When auto_en rises, the first poll starts on the next cycle.
- start while busy: ignored, not queued. start and auto expiry in the same cycle produce one poll.
- buttons holds its value between polls and changes only in DONE.
- Counter widths: $clog2 of max(LATCH_CYCLES, HALF_CYCLES, POLL_CYCLES)+1. No wrap occurs inside a phase.

Test Plan:
Bench pad model: parallel word loads while snes_latch=1; LSB is driven on snes_data after latch falls; the model shifts on each snes_clk rising edge and drives 1 after bit 15. Overrides: HALF_CYCLES=4, LATCH_CYCLES=8, POLL_CYCLES=400.
1. Reset, then start pulse with pad word 16'hFFFE (B pressed). Required: snes_latch high for exactly 8 cycles; 16 snes_clk low pulses of 4 cycles each; valid pulses once, 137 cycles after start; buttons=16'h0001; busy falls after valid.
2. Pad word 16'h0F00 (bits 0-7 pressed, A/X/L/R released, ID bits 1). Required: buttons=16'hF0FF.
3. auto_en=1 for 1300 cycles with start=0. Required: exactly 4 valid pulses, with latch rising edges 400 cycles apart. Deassert auto_en. Required: no further polls.
4. start re-asserted every cycle during a poll. Required: no second latch until the FSM returns to IDLE; a new poll begins only if start is high in IDLE.
5. Assert reset during the 5th LOW phase. Required: same-cycle snes_clk=1, snes_latch=0, busy=0, buttons=0, no valid. After release, a new start yields a correct word.
6. NUM_BITS=12 instance with pad word 16'h0000. Required: 12 clock pulses and buttons=16'h0FFF.
